// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry, receiver FSM
// encoding and counter sizing.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_START = 2'd1;
  localparam rx_state_t ST_DATA  = 2'd2;
  localparam rx_state_t ST_STOP  = 2'd3;

  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered first-word-fall-through FIFO; the head entry is always visible on
// o_rd_data, and a push into a full FIFO is dropped unless a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_full   = (count_q == (AW+1)'(DEPTH));
  assign o_empty  = (count_q == '0);
  assign pop_ok   = i_pop && !o_empty;
  assign push_ok  = i_push && (!o_full || pop_ok);
  assign count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  assign o_count  = count_q;
  // Empty slots may hold stale bytes, so the head is forced to zero when empty.
  assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define
  // validity, which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: synchronises the serial line, deserialises frames at
// mid-bit, buffers bytes in a FIFO and keeps sticky framing/overflow status.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
  output logic                      o_overflow,
  input  logic                      i_clr_status
);

  localparam int CW = baud_cnt_width(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      wait_high_q, wait_high_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overflow_q, overflow_d;
  logic                      push;
  logic                      frame_bad;
  logic                      pop;
  logic                      drop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  assign rx_s = sync_q[1];

  // NOTE: every always_comb output takes its hold value first so no path
  // through the case statement can leave a signal unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    push        = 1'b0;
    frame_bad   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wait_high_q) begin
          if (rx_s) wait_high_d = 1'b0;
        end else if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = FULL_LOAD;
          if (idx_q == LAST_IDX) state_d = ST_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // A low stop bit may be a break; stay deaf until the line idles.
          if (rx_s) push = 1'b1;
          else begin
            frame_bad   = 1'b1;
            wait_high_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop  = o_valid && i_ready;
  assign drop = push && fifo_full && !pop;

  assign frame_err_d = frame_bad ? 1'b1 : (i_clr_status ? 1'b0 : frame_err_q);
  assign overflow_d  = drop      ? 1'b1 : (i_clr_status ? 1'b0 : overflow_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], i_rx};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push    (push),
    .i_wr_data (shift_q),
    .i_pop     (pop),
    .o_rd_data (o_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (unused_fifo_count)
  );

  assign o_valid     = !fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor: table-driven frames, hand-written
// overflow/reset corner cases and a randomized run against a byte-level model.
module tb_uart_rx_monitor;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 155;  // start-edge drive to first cycle o_valid is seen

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic       i_clr_status = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overflow;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow),
    .i_clr_status (i_clr_status)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  logic       valid_prev = 1'b0;
  logic       rand_done = 1'b0;
  logic [7:0] rx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer model: records every accepted byte and the cycle o_valid rises.
  always @(negedge clk) begin
    if (o_valid && i_ready) rx_q.push_back(o_data);
    if (o_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= o_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = stop;
    tick(CPB);
    i_rx = 1'b1;
    tick(idle);
  endtask

  task automatic clr_status();
    i_clr_status = 1'b1;
    tick(1);
    i_clr_status = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_data"},  32'(o_data),  32'd0);
    check({tag, "_ferr"},  32'(o_frame_err), 32'd0);
    check({tag, "_ovf"},   32'(o_overflow),  32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    logic       exp_ferr;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    logic [7:0] exp_q [$];
    logic       ferr_exp;
    logic [7:0] b;
    logic       stop;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_count: 1, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, exp_count: 1, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h3C, stop: 1'b0, exp_count: 0, exp_ferr: 1'b1};
    vecs[3] = '{data: 8'h7E, stop: 1'b1, exp_count: 1, exp_ferr: 1'b1};

    tick(3);
    check_outputs_zero("reset");
    i_reset = 1'b0;
    tick(5);
    check_outputs_zero("post_reset");

    // Frame table with a free-running consumer.
    i_ready = 1'b1;
    foreach (vecs[k]) begin
      rx_q.delete();
      send_frame(vecs[k].data, vecs[k].stop, 8);
      check($sformatf("vec%0d_count", k), 32'(rx_q.size()), 32'(vecs[k].exp_count));
      if (vecs[k].exp_count == 1) begin
        check($sformatf("vec%0d_data", k), 32'(rx_q[0]), 32'(vecs[k].data));
        check($sformatf("vec%0d_latency", k), 32'(rise_cyc - start_cyc), 32'(LAT));
      end
      check($sformatf("vec%0d_ferr", k), 32'(o_frame_err), 32'(vecs[k].exp_ferr));
      check($sformatf("vec%0d_ovf", k), 32'(o_overflow), 32'd0);
    end
    clr_status();
    check("clr_ferr", 32'(o_frame_err), 32'd0);

    // Short low glitch must not start a frame; the next real frame still works.
    rx_q.delete();
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    tick(40);
    check("glitch_count", 32'(rx_q.size()), 32'd0);
    send_frame(8'h5A, 1'b1, 8);
    check("post_glitch_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("post_glitch_data", 32'(rx_q[0]), 32'h5A);

    // Overflow: five bytes into a four-deep FIFO with the consumer stalled.
    i_ready = 1'b0;
    rx_q.delete();
    for (int n = 1; n <= 5; n++) begin
      send_frame(8'(n), 1'b1, 4);
      if (n == 4) check("full_no_ovf", 32'(o_overflow), 32'd0);
    end
    check("ovf_set", 32'(o_overflow), 32'd1);
    check("ovf_valid", 32'(o_valid), 32'd1);
    check("ovf_head_held", 32'(o_data), 32'h01);
    i_ready = 1'b1;
    tick(10);
    check("ovf_drain_count", 32'(rx_q.size()), 32'd4);
    for (int n = 0; n < 4 && n < rx_q.size(); n++)
      check($sformatf("ovf_drain%0d", n), 32'(rx_q[n]), 32'(n + 1));
    check("ovf_sticky", 32'(o_overflow), 32'd1);
    clr_status();
    check("clr_ovf", 32'(o_overflow), 32'd0);

    // Full FIFO with a pop landing on the very cycle the fifth byte is pushed.
    i_ready = 1'b0;
    rx_q.delete();
    for (int n = 1; n <= 4; n++) send_frame(8'(n), 1'b1, 4);
    fork
      send_frame(8'h05, 1'b1, 4);
      begin
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
      end
    join
    check("simul_pop_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("simul_pop_data", 32'(rx_q[0]), 32'h01);
    check("simul_no_ovf", 32'(o_overflow), 32'd0);
    i_ready = 1'b1;
    tick(10);
    check("simul_drain_count", 32'(rx_q.size()), 32'd5);
    for (int n = 1; n < 5 && n < rx_q.size(); n++)
      check($sformatf("simul_drain%0d", n), 32'(rx_q[n]), 32'(n + 1));

    // Reset mid-frame with a queued byte and a set framing flag.
    i_ready = 1'b0;
    rx_q.delete();
    send_frame(8'h99, 1'b1, 4);
    send_frame(8'h10, 1'b0, 4);
    check("pre_reset_valid", 32'(o_valid), 32'd1);
    check("pre_reset_ferr", 32'(o_frame_err), 32'd1);
    fork
      send_frame(8'hFF, 1'b1, 8);
      begin
        repeat (60) @(posedge clk);
        #1 i_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("in_reset");
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset");
      end
    join
    i_ready = 1'b1;
    send_frame(8'h42, 1'b1, 8);
    check("reset_then_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("reset_then_data", 32'(rx_q[0]), 32'h42);
    check("reset_then_ferr", 32'(o_frame_err), 32'd0);

    // Randomized frames against a byte-level model with a random consumer.
    rx_q.delete();
    ferr_exp = 1'b0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          b    = 8'($urandom);
          stop = ($urandom_range(0, 3) != 0);
          if (stop) exp_q.push_back(b);
          else      ferr_exp = 1'b1;
          send_frame(b, stop, $urandom_range(2, 20));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          i_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    i_ready = 1'b1;
    tick(20);
    check("rand_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int n = 0; n < exp_q.size() && n < rx_q.size(); n++)
      check($sformatf("rand_byte%0d", n), 32'(rx_q[n]), 32'(exp_q[n]));
    check("rand_ferr", 32'(o_frame_err), 32'(ferr_exp));
    check("rand_ovf", 32'(o_overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
